// File: rtl/cc_mux_roundrobin_selector.sv
// Round-robin channel scheduler feeding the 8:1 bus mux selection input.
// Each requesting channel owns the bus for a programmable dwell time. All outputs
// are registered, so the mux select never glitches.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no grant; selection holds the last granted index
// ST_GRANT| one channel owns the bus; the dwell counter runs down to 1
module cc_mux_roundrobin_selector #(
   parameter int DATAWIDTH_MUX_SELECTION = 4,
   parameter int NUM_CHANNELS            = 8,
   parameter int DATAWIDTH_DWELL         = 4
) (
   input  logic                               CC_RRSEL_CLOCK_50,
   input  logic                               CC_RRSEL_RESET_InHigh,
   input  logic                               CC_RRSEL_enable_In,
   input  logic [7:0]                         CC_RRSEL_request_InBUS,
   input  logic                               CC_RRSEL_release_In,
   input  logic [DATAWIDTH_DWELL-1:0]         CC_RRSEL_dwell_InBUS,
   output logic [DATAWIDTH_MUX_SELECTION-1:0] CC_RRSEL_selection_OutBUS,
   output logic [7:0]                         CC_RRSEL_grant_OutBUS,
   output logic                               CC_RRSEL_valid_Out,
   output logic                               CC_RRSEL_switch_Out
);

   typedef enum logic {ST_IDLE, ST_GRANT} state_t;

   // Requests above NUM_CHANNELS-1 are never considered.
   localparam logic [7:0] REQ_MASK = 8'((9'd1 << NUM_CHANNELS) - 9'd1);

   state_t                     state_q;
   logic [2:0]                 ptr_q;
   logic [2:0]                 sel_q;
   logic [7:0]                 grant_q;
   logic                       valid_q;
   logic                       switch_q;
   logic [DATAWIDTH_DWELL-1:0] cnt_q;

   logic [7:0]                 req_v;
   logic                       any_req;
   logic [2:0]                 win_d;
   logic                       found;
   logic [2:0]                 idx;
   logic [DATAWIDTH_DWELL-1:0] dwell_load;
   logic                       grant_end;
   logic                       issue;

   assign req_v      = CC_RRSEL_request_InBUS & REQ_MASK;
   assign any_req    = |req_v;
   assign dwell_load = (CC_RRSEL_dwell_InBUS == '0) ? DATAWIDTH_DWELL'(1) : CC_RRSEL_dwell_InBUS;

   // Any one of these ends the running grant; overlapping causes are a single end event.
   assign grant_end = (cnt_q == DATAWIDTH_DWELL'(1)) || CC_RRSEL_release_In ||
                      !req_v[sel_q] || !CC_RRSEL_enable_In;

   // A new grant starts from IDLE or back-to-back at the end of the current one.
   assign issue = CC_RRSEL_enable_In && any_req && ((state_q == ST_IDLE) || grant_end);

   // Scan upward from the channel after the last owner; the owner itself is checked last,
   // so it only wins again when nobody else is asking.
   always_comb begin
      found = 1'b0;
      win_d = ptr_q;
      idx   = '0;
      for (int i = 1; i <= NUM_CHANNELS; i++) begin
         idx = 3'((int'(ptr_q) + i) % NUM_CHANNELS);
         if (!found && req_v[idx]) begin
            found = 1'b1;
            win_d = idx;
         end
      end
   end

   // Scheduler FSM with registered outputs.
   always_ff @(posedge CC_RRSEL_CLOCK_50 or posedge CC_RRSEL_RESET_InHigh) begin
      if (CC_RRSEL_RESET_InHigh) begin
         state_q  <= ST_IDLE;
         ptr_q    <= 3'(NUM_CHANNELS - 1);
         sel_q    <= '0;
         grant_q  <= '0;
         valid_q  <= 1'b0;
         switch_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         switch_q <= 1'b0;
         if (issue) begin
            state_q  <= ST_GRANT;
            sel_q    <= win_d;
            ptr_q    <= win_d;
            grant_q  <= 8'b1 << win_d;
            valid_q  <= 1'b1;
            switch_q <= 1'b1;
            cnt_q    <= dwell_load;
         end else if (state_q == ST_GRANT) begin
            if (grant_end) begin
               // selection is left alone so the mux output stays put while idle
               state_q <= ST_IDLE;
               grant_q <= '0;
               valid_q <= 1'b0;
               cnt_q   <= '0;
            end else begin
               cnt_q <= cnt_q - DATAWIDTH_DWELL'(1);
            end
         end
      end
   end

   assign CC_RRSEL_selection_OutBUS = DATAWIDTH_MUX_SELECTION'(sel_q);
   assign CC_RRSEL_grant_OutBUS     = grant_q;
   assign CC_RRSEL_valid_Out        = valid_q;
   assign CC_RRSEL_switch_Out       = switch_q;

endmodule
